// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Linear frequency-sweep sequencer for a DDS phase accumulator.
//               Takes a sweep descriptor over a valid/ready handshake and
//               steps the tuning word from start to stop, holding each value
//               for a programmable dwell. Single, sawtooth and triangle modes.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int PW      = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PW-1:0]      cfg_start,
    input  logic [PW-1:0]      cfg_stop,
    input  logic [PW-1:0]      cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PW-1:0]      cfg_phase,
    input  logic [1:0]         cfg_mode,
    input  logic               abort,
    output logic               dds_en,
    output logic [PW-1:0]      dds_freq,
    output logic [PW-1:0]      dds_phase,
    output logic               busy,
    output logic               done,
    output logic               step_tick
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DWELL = 2'd1;
    localparam logic [1:0] c_ST_STEP  = 2'd2;

    localparam logic [1:0] c_MODE_SAW = 2'd1;
    localparam logic [1:0] c_MODE_TRI = 2'd2;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_start;
    logic [PW-1:0]      r_stop;
    logic [PW-1:0]      r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_mode;
    logic [PW-1:0]      r_target;
    logic               r_dir_up;
    logic [DWELL_W-1:0] r_cnt;
    logic [PW-1:0]      r_freq;
    logic [PW-1:0]      r_phase;
    logic               r_active;
    logic               r_done;
    logic               r_tick;
    logic               r_ready;

    // One extra bit catches unsigned wrap in either direction
    logic [PW:0]        w_sum;
    logic [PW:0]        w_diff;
    logic [PW:0]        w_tgt_ext;
    logic [PW-1:0]      w_next;

    assign w_sum     = {1'b0, r_freq} + {1'b0, r_step};
    assign w_diff    = {1'b0, r_freq} - {1'b0, r_step};
    assign w_tgt_ext = {1'b0, r_target};

    // Next frequency word: advance by step, clamping onto target when reached or passed
    always_comb begin
        w_next = r_target;
        if (r_step != '0) begin
            if (r_dir_up) begin
                if (w_sum < w_tgt_ext) begin
                    w_next = w_sum[PW-1:0];
                end
            end else begin
                // A set top bit means the subtraction borrowed below zero
                if (!w_diff[PW] && (w_diff > w_tgt_ext)) begin
                    w_next = w_diff[PW-1:0];
                end
            end
        end
    end

    // Sweep sequencer: descriptor capture, dwell timing, stepping and leg turnaround
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_mode   <= '0;
            r_target <= '0;
            r_dir_up <= 1'b1;
            r_cnt    <= '0;
            r_freq   <= '0;
            r_phase  <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_tick   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_tick <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_valid) begin
                        r_start  <= cfg_start;
                        r_stop   <= cfg_stop;
                        r_step   <= cfg_step;
                        r_dwell  <= cfg_dwell;
                        r_mode   <= cfg_mode;
                        r_target <= cfg_stop;
                        r_dir_up <= (cfg_stop >= cfg_start);
                        r_cnt    <= cfg_dwell;
                        r_freq   <= cfg_start;
                        r_phase  <= cfg_phase;
                        r_active <= 1'b1;
                        r_ready  <= 1'b0;
                        r_state  <= c_ST_DWELL;
                    end
                end
                c_ST_DWELL: begin
                    if (abort) begin
                        r_active <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_freq != r_target) begin
                        r_state <= c_ST_STEP;
                    end else begin
                        // End of leg: behaviour depends on sweep mode
                        case (r_mode)
                            c_MODE_SAW: begin
                                r_freq <= r_start;
                                r_tick <= 1'b1;
                                r_cnt  <= r_dwell;
                            end
                            c_MODE_TRI: begin
                                r_target <= (r_target == r_stop) ? r_start : r_stop;
                                r_dir_up <= ~r_dir_up;
                                r_state  <= c_ST_STEP;
                            end
                            default: begin
                                r_done   <= 1'b1;
                                r_active <= 1'b0;
                                r_ready  <= 1'b1;
                                r_state  <= c_ST_IDLE;
                            end
                        endcase
                    end
                end
                c_ST_STEP: begin
                    if (abort) begin
                        r_active <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_freq  <= w_next;
                        r_tick  <= 1'b1;
                        r_cnt   <= r_dwell;
                        r_state <= c_ST_DWELL;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign dds_en    = r_active;
    assign busy      = r_active;
    assign dds_freq  = r_freq;
    assign dds_phase = r_phase;
    assign done      = r_done;
    assign step_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_sweep_ctrl
// Description : Self-checking bench for dds_sweep_ctrl. A sequence-level model
//               expands each descriptor into the expected per-cycle outputs,
//               which one compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    localparam int PW      = 32;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [PW-1:0]      cfg_start = '0;
    logic [PW-1:0]      cfg_stop  = '0;
    logic [PW-1:0]      cfg_step  = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [PW-1:0]      cfg_phase = '0;
    logic [1:0]         cfg_mode  = '0;
    logic               abort = 1'b0;
    logic               dds_en;
    logic [PW-1:0]      dds_freq;
    logic [PW-1:0]      dds_phase;
    logic               busy;
    logic               done;
    logic               step_tick;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.PW(PW), .DWELL_W(DWELL_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_phase (cfg_phase),
        .cfg_mode  (cfg_mode),
        .abort     (abort),
        .dds_en    (dds_en),
        .dds_freq  (dds_freq),
        .dds_phase (dds_phase),
        .busy      (busy),
        .done      (done),
        .step_tick (step_tick)
    );

    typedef struct packed {
        logic [PW-1:0] freq;
        logic [PW-1:0] phase;
        logic          en;
        logic          busy;
        logic          done;
        logic          tick;
        logic          ready;
    } obs_t;

    obs_t          exp_q[$];
    obs_t          tr[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    logic [PW-1:0] m_freq  = '0;
    logic [PW-1:0] m_phase = '0;
    obs_t          cmp_a;
    obs_t          cmp_e;

    function automatic obs_t mk(input logic [PW-1:0] f, input logic [PW-1:0] ph,
                                input logic en, input logic dn, input logic tk,
                                input logic rdy);
        obs_t o;
        o.freq  = f;
        o.phase = ph;
        o.en    = en;
        o.busy  = en;
        o.done  = dn;
        o.tick  = tk;
        o.ready = rdy;
        return o;
    endfunction

    // Next value on a leg heading for tgt: move by s, never beyond tgt
    function automatic longint nxt(input longint v, input longint tgt, input longint s);
        if (s == 0) return tgt;
        if (tgt >= v) return (v + s >= tgt) ? tgt : v + s;
        return (v - s <= tgt) ? tgt : v - s;
    endfunction

    function automatic void add(input longint f, input logic [PW-1:0] ph,
                                input bit t, input int n);
        logic [PW-1:0] fw;
        fw = f[PW-1:0];
        for (int i = 0; i < n; i++) tr.push_back(mk(fw, ph, 1'b1, 1'b0, t && (i == 0), 1'b0));
    endfunction

    // Expected outputs for every cycle after the accepting edge
    function automatic void build(input longint s, input longint p, input longint st,
                                  input int d, input logic [PW-1:0] ph,
                                  input int mode, input int maxlen);
        longint        cur;
        longint        tgt;
        logic [PW-1:0] fw;
        tr.delete();
        cur = s;
        tgt = p;
        add(cur, ph, 1'b0, d + 1);
        while (tr.size() < maxlen) begin
            if (cur != tgt) begin
                add(cur, ph, 1'b0, 1);
                cur = nxt(cur, tgt, st);
                add(cur, ph, 1'b1, d + 1);
            end else if (mode == 1) begin
                cur = s;
                add(cur, ph, 1'b1, d + 1);
            end else if (mode == 2) begin
                tgt = (tgt == p) ? s : p;
                add(cur, ph, 1'b0, 1);
                cur = nxt(cur, tgt, st);
                add(cur, ph, 1'b1, d + 1);
            end else begin
                fw = cur[PW-1:0];
                tr.push_back(mk(fw, ph, 1'b0, 1'b1, 1'b0, 1'b1));
                break;
            end
        end
        while (tr.size() > maxlen) void'(tr.pop_back());
    endfunction

    task automatic lit(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushq(input obs_t o);
        exp_q.push_back(o);
        m_freq  = o.freq;
        m_phase = o.phase;
    endtask

    function automatic obs_t idle_obs();
        return mk(m_freq, m_phase, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pushq(idle_obs());
        cyc(n);
    endtask

    task automatic set_cfg(input longint s, input longint p, input longint st, input int d,
                           input logic [PW-1:0] ph, input int mode);
        cfg_start = s[PW-1:0];
        cfg_stop  = p[PW-1:0];
        cfg_step  = st[PW-1:0];
        cfg_dwell = d[DWELL_W-1:0];
        cfg_phase = ph;
        cfg_mode  = mode[1:0];
    endtask

    // One sweep; cut >= 0 interrupts it (abort or reset) while trace[cut] is visible
    task automatic run(input longint s, input longint p, input longint st, input int d,
                       input logic [PW-1:0] ph, input int mode, input int maxlen,
                       input int cut, input bit use_rst);
        int len;
        set_cfg(s, p, st, d, ph, mode);
        cfg_valid = 1'b1;
        pushq(idle_obs());
        build(s, p, st, d, ph, mode, maxlen);
        if (cut >= 0) while (tr.size() > cut + 1) void'(tr.pop_back());
        len = tr.size();
        foreach (tr[i]) pushq(tr[i]);
        if (cut >= 0) begin
            if (use_rst) pushq(mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b1));
            else         pushq(idle_obs());
        end
        cyc(1);
        cfg_valid = 1'b0;
        if (cut < 0) begin
            cyc(len);
        end else begin
            cyc(cut);
            if (use_rst) rst = 1'b1;
            else         abort = 1'b1;
            cyc(1);
            rst   = 1'b0;
            abort = 1'b0;
            cyc(1);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_a = mk(dds_freq, dds_phase, dds_en, done, step_tick, cfg_ready);
            cmp_a.busy = busy;
            n_chk++;
            if (cmp_a === cmp_e) n_pass++;
            else $display("FAIL cycle t=%0t: actual freq=%0d phase=%0h en=%b busy=%b done=%b tick=%b ready=%b; required freq=%0d phase=%0h en=%b busy=%b done=%b tick=%b ready=%b",
                          $time, cmp_a.freq, cmp_a.phase, cmp_a.en, cmp_a.busy, cmp_a.done,
                          cmp_a.tick, cmp_a.ready, cmp_e.freq, cmp_e.phase, cmp_e.en,
                          cmp_e.busy, cmp_e.done, cmp_e.tick, cmp_e.ready);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1;
        int l2;
        // Reset state
        cyc(2);
        pushq(mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b0;
        cyc(1);
        idle(2);

        // Abort while idle is ignored
        abort = 1'b1;
        pushq(idle_obs());
        cyc(1);
        abort = 1'b0;
        idle(2);

        // Single up sweep
        build(100, 130, 10, 2, 32'h1234_5678, 0, 200);
        lit("up_len", tr.size(), 16);
        lit("up_step_hold", tr[3].freq, 100);
        lit("up_first_change", tr[4].freq, 110);
        lit("up_first_tick", tr[4].tick, 1);
        lit("up_done_freq", tr[15].freq, 130);
        run(100, 130, 10, 2, 32'h1234_5678, 0, 200, -1, 1'b0);
        idle(2);

        // Descending with clamp (mode 3 behaves as single)
        build(1000, 975, 10, 0, 32'h0000_abcd, 3, 200);
        lit("down_len", tr.size(), 8);
        lit("down_clamp", tr[6].freq, 975);
        lit("down_done", tr[7].done, 1);
        run(1000, 975, 10, 0, 32'h0000_abcd, 3, 200, -1, 1'b0);
        idle(1);

        // Clamp near the top of the word range
        build(64'hFFFF_FFEC, 64'hFFFF_FFFF, 16, 0, 32'h8000_0001, 0, 200);
        lit("ovf_mid", tr[2].freq, 64'hFFFF_FFFC);
        lit("ovf_clamp", tr[4].freq, 64'hFFFF_FFFF);
        run(64'hFFFF_FFEC, 64'hFFFF_FFFF, 16, 0, 32'h8000_0001, 0, 200, -1, 1'b0);
        idle(2);

        // Sawtooth, aborted while 10 is newly visible
        build(0, 20, 10, 1, 32'h0000_0f0f, 1, 200);
        lit("saw_wrap_freq", tr[8].freq, 0);
        lit("saw_wrap_tick", tr[8].tick, 1);
        lit("saw_second_10", tr[11].freq, 10);
        run(0, 20, 10, 1, 32'h0000_0f0f, 1, 200, 11, 1'b0);
        idle(3);

        // Triangle, aborted at the second peak
        build(0, 20, 10, 0, 32'h0000_0077, 2, 200);
        lit("tri_desc", tr[6].freq, 10);
        lit("tri_floor", tr[8].freq, 0);
        lit("tri_peak2", tr[12].freq, 20);
        run(0, 20, 10, 0, 32'h0000_0077, 2, 200, 12, 1'b0);
        idle(2);

        // Reset in the middle of a sweep
        run(100, 130, 10, 2, 32'h5555_aaaa, 0, 200, 5, 1'b1);
        idle(2);

        // cfg_valid held through a sweep; second descriptor (step 0) taken right after done
        build(5, 50, 0, 1, 32'h0000_0042, 0, 200);
        lit("step0_len", tr.size(), 6);
        lit("step0_jump", tr[3].freq, 50);
        set_cfg(7, 9, 1, 0, 32'h0000_0011, 0);
        cfg_valid = 1'b1;
        pushq(idle_obs());
        build(7, 9, 1, 0, 32'h0000_0011, 0, 200);
        l1 = tr.size();
        foreach (tr[i]) pushq(tr[i]);
        build(5, 50, 0, 1, 32'h0000_0042, 0, 200);
        l2 = tr.size();
        foreach (tr[i]) pushq(tr[i]);
        cyc(1);
        set_cfg(5, 50, 0, 1, 32'h0000_0042, 0);
        cyc(l1);
        cfg_valid = 1'b0;
        cyc(l2);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the tuning-word, phase-offset and enable inputs of a DDS / orthogonal DDS phase accumulator. It accepts a sweep descriptor through a valid/ready handshake: start word, stop word, step magnitude, dwell time, phase offset and mode. It then steps the frequency word linearly from start to stop, holding each value for a programmable number of cycles. Single-shot, sawtooth-repeat and triangle modes are supported, with abort and a done pulse for upstream control logic.

Parameters:
PW, 32, width of frequency/phase tuning words (matches DDS PW)
DWELL_W, 16, width of dwell counter

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid && cfg_ready
cfg_start  in  PW  start frequency word (unsigned)
cfg_stop  in  PW  stop frequency word (unsigned)
cfg_step  in  PW  step magnitude (unsigned)
cfg_dwell  in  DWELL_W  each frequency held cfg_dwell+1 cycles
cfg_phase  in  PW  phase offset passed to DDS
cfg_mode  in  2  0 single, 1 sawtooth repeat, 2 triangle, 3 treated as single
abort  in  1  terminate active sweep
dds_en  out  1  DDS enable
dds_freq  out  PW  DDS frequency word
dds_phase  out  PW  DDS phase offset
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on normal sweep completion
step_tick  out  1  one-cycle pulse coincident with each dds_freq change after the first

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: dds_freq=0, dds_phase=0, dds_en=0, busy=0, done=0, step_tick=0, state IDLE, cfg_ready=1.
- States: IDLE, DWELL, STEP. cfg_ready = (state==IDLE). busy = dds_en = (state!=IDLE), all registered.
- Accept (IDLE, cfg_valid=1), at the accepting edge:
  - Latch the descriptor.
  - dds_freq<=cfg_start, dds_phase<=cfg_phase.
  - dir<=up if cfg_stop>=cfg_start (unsigned), else down.
  - dwell_cnt<=cfg_dwell; go to DWELL.
- DWELL: decrement dwell_cnt each cycle. When dwell_cnt==0:
  - If dds_freq!=target, go to STEP.
  - Otherwise it is an end-of-leg event (see below).
  - Net effect: each frequency value is present for exactly cfg_dwell+1 cycles, plus one STEP cycle for every value except the first. STEP holds the old value.
- STEP (1 cycle):
  - Compute next = dds_freq ± step in PW+1 bits.
  - Clamp to target when next would reach or pass target, including unsigned over/underflow.
  - step==0 jumps directly to target.
  - Register dds_freq<=next, pulse step_tick, reload dwell_cnt, return to DWELL.
- End-of-leg, by mode:
  - single: done=1 for one cycle, state IDLE; dds_freq/dds_phase hold last value, dds_en=0 (DDS output freezes).
  - sawtooth: dds_freq<=start, step_tick=1, reload dwell, stay in DWELL; never completes without abort.
  - triangle: swap target between stop and start, invert dir, go to STEP (first step of the return leg).
- start==stop: single = one dwell period then done; sawtooth/triangle = constant frequency until abort.
- abort (any non-IDLE state): next edge enters IDLE with done=0 and dds_freq held; abort in IDLE is ignored. Abort takes priority over a simultaneous end-of-leg.
- cfg_valid while busy: ignored, no back-pressure loss; the upstream holds it until cfg_ready.
- Reset mid-sweep returns every output to its reset value at the next edge.
- done and cfg_ready rise on the same edge, so a new descriptor can be accepted on the cycle immediately after done.

Test Plan:
- Single up: start=100, stop=130, step=10, dwell=2, mode 0 -> dds_freq 100,110,120,130, each held 3 cycles (+1 STEP cycle for 110..130), 3 step_tick pulses, done pulses once, busy falls with done.
- Clamp/down: start=1000, stop=975, step=10, dwell=0 -> dds_freq 1000,990,980,975 then done; no undershoot.
- Overflow clamp: start=2^32-20, stop=2^32-1, step=16 -> 2^32-20, 2^32-4, 2^32-1; no wrap to small values.
- Sawtooth: start=0, stop=20, step=10, dwell=1 -> sequence 0,10,20,0,10,20,...; abort after 10 cycles -> busy=0 next cycle, done never asserted, dds_freq holds.
- Triangle: start=0, stop=20, step=10, dwell=0 -> 0,10,20,10,0,10,... with step_tick on every change.
- Handshake/reset: cfg_valid held during busy -> accepted only the cycle after done; rst asserted mid-sweep -> all outputs 0, cfg_ready=1 next cycle; step=0 with start=5, stop=50 -> 5 then 50 then done.
